// File: rtl/instruction_fetch_ctrl.sv
// Instruction fetch sequencer: PC, IF/ID register, stall/branch handling,
// and arbitration of the instruction memory port with the program loader.
module instruction_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_fault,
  output logic [31:0] instr_count
);

  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        fault_q, fault_d;
  logic [31:0] cnt_q, cnt_d;

  logic load_ok;
  logic pc_bad;

  assign load_ok = (load_addr[1:0] == 2'b00) && (load_addr < LIMIT);
  assign pc_bad  = (pc_q[1:0] != 2'b00) || (pc_q >= LIMIT);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    ifpc_d   = ifpc_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;
    mem_addr = pc_q;
    mem_we   = 1'b0;
    unique case (state_q)
      BOOT: begin
        valid_d = 1'b0;
        if (load_en) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else begin
          state_d = RUN;
        end
      end
      LOAD: begin
        mem_addr = load_addr;
        // A reset in this cycle must not commit a half-finished load.
        mem_we   = load_we & load_ok & ~reset;
        valid_d  = 1'b0;
        cnt_d    = '0;
        if (!load_en) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end
      RUN: begin
        if (load_en) begin
          state_d = LOAD;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else if (branch_taken) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
          instr_d = '0;
        end else if (pc_bad) begin
          state_d = FAULT;
          fault_d = 1'b1;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = mem_rdata;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
          if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
        end
      end
      FAULT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_wdata   = load_data;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ifpc_q;
  assign fetch_fault = fault_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Directed bench for instruction_fetch_ctrl with a behavioural
// instruction memory attached to its memory port.
module tb_instruction_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en, load_we;
  logic [31:0] load_addr, load_data;
  logic        stall, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic        if_valid, fetch_fault;
  logic [31:0] if_instr, if_pc, instr_count;

  logic [31:0] mem [0:1023];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instruction_fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .load_en       (load_en),
    .load_we       (load_we),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .fetch_fault   (fetch_fault),
    .instr_count   (instr_count)
  );

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk)
    if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic v,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] cnt);
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, ".instr"}, if_instr, ins);
    chk({tag, ".pc"}, if_pc, pc);
    chk({tag, ".count"}, instr_count, cnt);
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    #1;
    chk("load_we_ok", {31'd0, mem_we}, 32'd1);
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[1023] = 32'hDEAD_BEEF;
    reset = 1'b1; load_en = 1'b0; load_we = 1'b0;
    load_addr = '0; load_data = '0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    step(); step();
    chk_if("reset", 1'b0, 32'h0, 32'h0, 32'h0);
    chk("reset.fault", {31'd0, fetch_fault}, 32'd0);

    // BOOT -> LOAD, write four words
    reset = 1'b0; load_en = 1'b1;
    step();
    load_word(32'h0, 32'h2001_000A);
    load_word(32'h4, 32'h2002_000B);
    load_word(32'h8, 32'h0022_1820);
    load_word(32'hC, 32'hAC03_0000);
    load_addr = 32'h1000; #1;
    chk("load_oor_we", {31'd0, mem_we}, 32'd0);
    load_addr = 32'h2; #1;
    chk("load_mis_we", {31'd0, mem_we}, 32'd0);
    chk("load_addr", mem_addr, 32'h2);
    load_we = 1'b0; load_en = 1'b0;
    step();
    chk("run.addr", mem_addr, 32'h0);
    chk("run.we", {31'd0, mem_we}, 32'd0);

    step(); chk_if("f0", 1'b1, 32'h2001_000A, 32'h0, 32'd1);
    step(); chk_if("f1", 1'b1, 32'h2002_000B, 32'h4, 32'd2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_if("stall", 1'b1, 32'h2002_000B, 32'h4, 32'd2);
    end
    stall = 1'b0;
    step(); chk_if("f2", 1'b1, 32'h0022_1820, 32'h8, 32'd3);
    step(); chk_if("f3", 1'b1, 32'hAC03_0000, 32'hC, 32'd4);

    // plain branch back to 8, then stalled branch at pc=0xC
    branch_taken = 1'b1; branch_target = 32'h8;
    step(); chk_if("br1", 1'b0, 32'h0, 32'hC, 32'd4);
    branch_taken = 1'b0;
    step(); chk_if("br1t", 1'b1, 32'h0022_1820, 32'h8, 32'd5);
    chk("pc_c", mem_addr, 32'hC);
    stall = 1'b1; branch_taken = 1'b1;
    step(); chk_if("br2", 1'b0, 32'h0, 32'h8, 32'd5);
    stall = 1'b0; branch_taken = 1'b0;
    step(); chk_if("br2t", 1'b1, 32'h0022_1820, 32'h8, 32'd6);

    // misaligned target
    branch_taken = 1'b1; branch_target = 32'h6;
    step(); chk_if("br6", 1'b0, 32'h0, 32'h8, 32'd6);
    chk("br6.fault", {31'd0, fetch_fault}, 32'd0);
    branch_taken = 1'b0;
    step();
    chk("mis.fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis.valid", {31'd0, if_valid}, 32'd0);
    load_en = 1'b1; load_we = 1'b1; load_addr = 32'h0;
    step();
    chk("flt.fault", {31'd0, fetch_fault}, 32'd1);
    chk("flt.we", {31'd0, mem_we}, 32'd0);
    chk("flt.addr", mem_addr, 32'h6);
    chk("flt.valid", {31'd0, if_valid}, 32'd0);
    load_en = 1'b0; load_we = 1'b0;
    reset = 1'b1;
    step();
    chk("rst.fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst.count", instr_count, 32'd0);

    // sequential run to the top of memory
    reset = 1'b0;
    step();
    for (int i = 0; i < 1023; i++) step();
    chk_if("f3f8", 1'b1, 32'h0, 32'hFF8, 32'd1023);
    step(); chk_if("fffc", 1'b1, 32'hDEAD_BEEF, 32'hFFC, 32'd1024);
    chk("top.fault", {31'd0, fetch_fault}, 32'd0);
    step();
    chk("top.fault2", {31'd0, fetch_fault}, 32'd1);
    chk("top.valid", {31'd0, if_valid}, 32'd0);

    // load request mid-run
    reset = 1'b1; step();
    reset = 1'b0; step();
    step(); chk_if("m0", 1'b1, 32'h2001_000A, 32'h0, 32'd1);
    step(); chk_if("m1", 1'b1, 32'h2002_000B, 32'h4, 32'd2);
    load_en = 1'b1; load_addr = 32'h40;
    step();
    chk("ld.valid", {31'd0, if_valid}, 32'd0);
    chk("ld.count", instr_count, 32'd0);
    chk("ld.addr", mem_addr, 32'h40);
    load_en = 1'b0;
    step();
    chk("rel.addr", mem_addr, 32'h0);
    step(); chk_if("r0", 1'b1, 32'h2001_000A, 32'h0, 32'd1);

    // reset during a load write
    load_en = 1'b1;
    step();
    load_we = 1'b1; load_addr = 32'h40; load_data = 32'h1234_5678;
    #1;
    chk("rl.we", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    step();
    chk("rl.we0", {31'd0, mem_we}, 32'd0);
    chk("rl.mem", mem[16], 32'h0);
    chk("rl.count", instr_count, 32'd0);
    reset = 1'b0; load_en = 1'b0; load_we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
